// File: rtl/trd_sched.sv
// Round-robin fetch scheduler for the 8-thread barrel pipeline: owns the active mask, free-ID allocation, spawn and kill.
// Optional issued-fetch counter is enabled by defining TRD_ISSUE_CNT_EN; otherwise issue_cnt is tied to zero.
module trd_sched #(
  parameter int NTRD     = 8,
  parameter int BOOT_TRD = 0,
  localparam int IDW     = $clog2(NTRD)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            spawn_req,
  input  logic            kill_req,
  input  logic [IDW-1:0]  kill_trd,
  input  logic [NTRD-1:0] block_mask,
  output logic [IDW-1:0]  trd_fetch,
  output logic            fetch_vld,
  output logic [IDW-1:0]  new_trd_id,
  output logic            new_trd_avail,
  output logic            spawn_drop,
  output logic [NTRD-1:0] active_mask,
  output logic            all_done,
  output logic [31:0]     issue_cnt
);

  logic [NTRD-1:0]   kill_vec;
  logic [NTRD-1:0]   spawn_vec;
  logic [NTRD-1:0]   mask_nxt;
  logic [NTRD-1:0]   elig;
  logic [2*NTRD-1:0] elig_dbl;
  logic [NTRD-1:0]   elig_rot;
  logic [IDW-1:0]    rr_start;
  logic [IDW-1:0]    rr_off;
  logic [IDW-1:0]    rr_sel;
  logic              rr_hit;
  logic              spawn_eff;

  always_comb begin
    new_trd_id    = '0;
    new_trd_avail = 1'b0;
    for (int i = NTRD - 1; i >= 0; i--) begin
      if (!active_mask[i]) begin
        new_trd_id    = IDW'(i);
        new_trd_avail = 1'b1;
      end
    end
  end

  // Spawn always targets a free slot, so clearing the kill first never cancels it.
  assign spawn_eff = spawn_req & ~stall & ~all_done;
  assign kill_vec  = kill_req ? (NTRD'(1) << kill_trd) : '0;
  assign spawn_vec = (spawn_eff & new_trd_avail) ? (NTRD'(1) << new_trd_id) : '0;
  assign mask_nxt  = (active_mask & ~kill_vec) | spawn_vec;
  assign elig      = active_mask & ~block_mask & ~kill_vec;

  // Rotate so the thread after the current one sits at bit 0, then pick the lowest set bit.
  assign rr_start = trd_fetch + IDW'(1);
  assign elig_dbl = {elig, elig} >> rr_start;
  assign elig_rot = elig_dbl[NTRD-1:0];

  always_comb begin
    rr_hit = 1'b0;
    rr_off = '0;
    for (int i = NTRD - 1; i >= 0; i--) begin
      if (elig_rot[i]) begin
        rr_off = IDW'(i);
        rr_hit = 1'b1;
      end
    end
  end

  assign rr_sel = rr_start + rr_off;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_mask <= NTRD'(1) << BOOT_TRD;
      trd_fetch   <= IDW'(BOOT_TRD);
      fetch_vld   <= 1'b0;
      spawn_drop  <= 1'b0;
      all_done    <= 1'b0;
    end else begin
      active_mask <= mask_nxt;
      spawn_drop  <= spawn_eff & ~new_trd_avail;
      all_done    <= all_done | (mask_nxt == '0);
      if (mask_nxt == '0) begin
        fetch_vld <= 1'b0;
      end else if (!stall) begin
        fetch_vld <= rr_hit;
        if (rr_hit) trd_fetch <= rr_sel;
      end
    end
  end

`ifdef TRD_ISSUE_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 32'h0;
    else if (fetch_vld && !stall) cnt_q <= cnt_q + 32'd1;
  end

  assign issue_cnt = cnt_q;
`else
  assign issue_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_trd_sched.sv
// Table-driven bench for trd_sched: each vector row carries inputs and the expected registered outputs,
// which are queued when the row is driven and compared after the following clock edge.
module tb_trd_sched;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 1'b0;
  logic       spawn_req = 1'b0;
  logic       kill_req = 1'b0;
  logic [2:0] kill_trd = 3'd0;
  logic [7:0] block_mask = 8'h00;
  logic [2:0] trd_fetch;
  logic       fetch_vld;
  logic [2:0] new_trd_id;
  logic       new_trd_avail;
  logic       spawn_drop;
  logic [7:0] active_mask;
  logic       all_done;
  logic [31:0] issue_cnt;

  trd_sched #(.NTRD(8), .BOOT_TRD(0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .spawn_req(spawn_req),
    .kill_req(kill_req), .kill_trd(kill_trd), .block_mask(block_mask),
    .trd_fetch(trd_fetch), .fetch_vld(fetch_vld), .new_trd_id(new_trd_id),
    .new_trd_avail(new_trd_avail), .spawn_drop(spawn_drop),
    .active_mask(active_mask), .all_done(all_done), .issue_cnt(issue_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       stall, spawn, kill;
    logic [2:0] ktrd;
    logic [7:0] blk;
    logic [7:0] e_mask;
    logic [2:0] e_fetch;
    logic       e_vld, e_drop, e_done;
  } vec_t;

  typedef struct {
    logic [7:0]  mask;
    logic [2:0]  fetch;
    logic        vld, drop, done;
    logic [2:0]  nid;
    logic        avail;
    logic [31:0] cnt;
  } exp_t;

  vec_t        tbl[$];
  vec_t        cnt_tbl[$];
  exp_t        sb[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic        prev_vld = 1'b0;
  logic [31:0] exp_cnt = 32'h0;

  function automatic vec_t mk(logic s, logic sp, logic k, logic [2:0] kt, logic [7:0] b,
                              logic [7:0] m, logic [2:0] f, logic v, logic d, logic dn);
    vec_t r;
    r.stall = s; r.spawn = sp; r.kill = k; r.ktrd = kt; r.blk = b;
    r.e_mask = m; r.e_fetch = f; r.e_vld = v; r.e_drop = d; r.e_done = dn;
    return r;
  endfunction

  // Reference free-ID search: scan upward for the first clear bit.
  function automatic logic [3:0] free_of(logic [7:0] m);
    for (int i = 0; i < 8; i++) begin
      if (!m[i]) return {1'b1, 3'(i)};
    end
    return 4'b0000;
  endfunction

  task automatic chk(string name, int row, logic [31:0] got, logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s row %0d: got %0h want %0h", name, row, got, want);
  endtask

  task automatic check_out(int row);
    exp_t e;
    if (sb.size() == 0) begin
      n_total++;
      $display("FAIL scoreboard row %0d: got empty queue want entry", row);
      return;
    end
    e = sb.pop_front();
    chk("active_mask", row, 32'(active_mask), 32'(e.mask));
    chk("trd_fetch", row, 32'(trd_fetch), 32'(e.fetch));
    chk("fetch_vld", row, 32'(fetch_vld), 32'(e.vld));
    chk("spawn_drop", row, 32'(spawn_drop), 32'(e.drop));
    chk("all_done", row, 32'(all_done), 32'(e.done));
    chk("new_trd_id", row, 32'(new_trd_id), 32'(e.nid));
    chk("new_trd_avail", row, 32'(new_trd_avail), 32'(e.avail));
    chk("issue_cnt", row, issue_cnt, e.cnt);
  endtask

  task automatic apply(input vec_t v, input int row);
    exp_t       e;
    logic [3:0] fr;
    @(negedge clk);
    stall = v.stall; spawn_req = v.spawn; kill_req = v.kill;
    kill_trd = v.ktrd; block_mask = v.blk;
    fr = free_of(v.e_mask);
    e.mask = v.e_mask; e.fetch = v.e_fetch; e.vld = v.e_vld;
    e.drop = v.e_drop; e.done = v.e_done; e.nid = fr[2:0]; e.avail = fr[3];
`ifdef TRD_ISSUE_CNT_EN
    if (prev_vld && !v.stall) exp_cnt = exp_cnt + 32'd1;
`endif
    e.cnt = exp_cnt;
    prev_vld = v.e_vld;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check_out(row);
  endtask

  initial begin
    // stall spawn kill ktrd blk | mask fetch vld drop done
    tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'h01,3'd0,1,0,0)); // first edge after release
    tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'h01,3'd0,1,0,0));
    tbl.push_back(mk(0,1,0,3'd0,8'h00, 8'h03,3'd0,1,0,0)); // three spawns
    tbl.push_back(mk(0,1,0,3'd0,8'h00, 8'h07,3'd1,1,0,0));
    tbl.push_back(mk(0,1,0,3'd0,8'h00, 8'h0F,3'd2,1,0,0));
    tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'h0F,3'd3,1,0,0));
    tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'h0F,3'd0,1,0,0));
    tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'h0F,3'd1,1,0,0));
    tbl.push_back(mk(0,0,0,3'd0,8'h04, 8'h0F,3'd3,1,0,0)); // thread 2 blocked, skipped
    tbl.push_back(mk(1,0,0,3'd0,8'h00, 8'h0F,3'd3,1,0,0)); // 3-cycle stall
    tbl.push_back(mk(1,0,0,3'd0,8'h00, 8'h0F,3'd3,1,0,0));
    tbl.push_back(mk(1,0,0,3'd0,8'h00, 8'h0F,3'd3,1,0,0));
    tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'h0F,3'd0,1,0,0));
    tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'h0F,3'd1,1,0,0));
    tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'h0F,3'd2,1,0,0));
    tbl.push_back(mk(0,0,1,3'd3,8'h00, 8'h07,3'd0,1,0,0)); // killed thread 3 not selected
    tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'h07,3'd1,1,0,0));
    tbl.push_back(mk(0,1,0,3'd0,8'h00, 8'h0F,3'd2,1,0,0)); // fill to FF
    tbl.push_back(mk(0,1,0,3'd0,8'h00, 8'h1F,3'd3,1,0,0));
    tbl.push_back(mk(0,1,0,3'd0,8'h00, 8'h3F,3'd4,1,0,0));
    tbl.push_back(mk(0,1,0,3'd0,8'h00, 8'h7F,3'd5,1,0,0));
    tbl.push_back(mk(0,1,0,3'd0,8'h00, 8'hFF,3'd6,1,0,0));
    tbl.push_back(mk(0,1,0,3'd0,8'h00, 8'hFF,3'd7,1,1,0)); // full: drop pulse
    tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'hFF,3'd0,1,0,0));
    tbl.push_back(mk(1,1,0,3'd0,8'h00, 8'hFF,3'd0,1,0,0)); // stalled spawn: no drop
    tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'hFF,3'd1,1,0,0));
    tbl.push_back(mk(0,0,1,3'd7,8'h00, 8'h7F,3'd2,1,0,0)); // kill down to thread 0
    tbl.push_back(mk(0,0,1,3'd6,8'h00, 8'h3F,3'd3,1,0,0));
    tbl.push_back(mk(0,0,1,3'd5,8'h00, 8'h1F,3'd4,1,0,0));
    tbl.push_back(mk(0,0,1,3'd4,8'h00, 8'h0F,3'd0,1,0,0));
    tbl.push_back(mk(0,0,1,3'd3,8'h00, 8'h07,3'd1,1,0,0));
    tbl.push_back(mk(0,0,1,3'd2,8'h00, 8'h03,3'd0,1,0,0));
    tbl.push_back(mk(0,0,1,3'd1,8'h00, 8'h01,3'd0,1,0,0));
    tbl.push_back(mk(0,0,1,3'd5,8'h00, 8'h01,3'd0,1,0,0)); // kill of inactive thread: no-op
    tbl.push_back(mk(0,1,1,3'd1,8'h00, 8'h03,3'd0,1,0,0)); // spawn + kill of the free ID
    tbl.push_back(mk(0,0,1,3'd1,8'h00, 8'h01,3'd0,1,0,0));
    tbl.push_back(mk(0,0,1,3'd0,8'h00, 8'h00,3'd0,0,0,1)); // last thread killed
    tbl.push_back(mk(0,1,0,3'd0,8'h00, 8'h00,3'd0,0,0,1)); // spawn ignored once done
    tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'h00,3'd0,0,0,1));

    cnt_tbl.push_back(mk(0,0,0,3'd0,8'h00, 8'h01,3'd0,1,0,0));
    for (int i = 0; i < 10; i++)
      cnt_tbl.push_back(mk((i == 3 || i == 7) ? 1'b1 : 1'b0,0,0,3'd0,8'h00, 8'h01,3'd0,1,0,0));

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_mask", -1, 32'(active_mask), 32'h01);
    chk("rst_fetch", -1, 32'(trd_fetch), 32'h0);
    chk("rst_vld", -1, 32'(fetch_vld), 32'h0);
    chk("rst_drop", -1, 32'(spawn_drop), 32'h0);
    chk("rst_done", -1, 32'(all_done), 32'h0);
    chk("rst_nid", -1, 32'(new_trd_id), 32'h1);
    chk("rst_avail", -1, 32'(new_trd_avail), 32'h1);
    chk("rst_cnt", -1, issue_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int r = 0; r < tbl.size(); r++) apply(tbl[r], r);

    // Asynchronous mid-run reset, checked before any clock edge
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_mask", 100, 32'(active_mask), 32'h01);
    chk("async_done", 100, 32'(all_done), 32'h0);
    chk("async_vld", 100, 32'(fetch_vld), 32'h0);
    chk("async_cnt", 100, issue_cnt, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    prev_vld = 1'b0;
    exp_cnt  = 32'h0;
    spawn_req = 1'b0; kill_req = 1'b0; stall = 1'b0;

    for (int r = 0; r < cnt_tbl.size(); r++) apply(cnt_tbl[r], 200 + r);
`ifdef TRD_ISSUE_CNT_EN
    chk("cnt_after_10", 300, issue_cnt, 32'd8);
    force dut.cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.cnt_q;
    exp_cnt = 32'hFFFF_FFFF;
    apply(mk(0,0,0,3'd0,8'h00, 8'h01,3'd0,1,0,0), 301);
`else
    chk("cnt_tied", 300, issue_cnt, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
